// File: rtl/pipe_pkg.sv
// Shared types for the pipeline result sink: FSM states, stamp width and
// the layout of one recorded match.
package pipe_pkg;

  localparam int STAMP_W = 8;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

endpackage

// File: rtl/pipe_sink_if.sv
// Result stream in and match FIFO out, bundled as one bus. The sink is the
// slave; the pipeline/host side is the master.
interface pipe_sink_if #(
  parameter int WIDTH = 8
);

  logic                         in_valid;
  logic [WIDTH-1:0]             in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out_data;
  logic [pipe_pkg::STAMP_W-1:0] out_stamp;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_stamp
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_stamp
  );

endinterface

// File: rtl/sink_fifo.sv
// Synchronous FIFO with valid/ready pop and wrap-bit pointers. A push while
// full only succeeds if the head is popped in the same cycle; otherwise it is
// reported on 'drop'. The head is read straight from storage, so a push into
// an empty FIFO shows up one cycle later (no bypass).
module sink_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         pop_valid,
  output logic [W-1:0] pop_data,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         empty;
  logic         full;
  logic         pop;
  logic         push_ok;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = !empty && pop_ready;
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign pop_valid = !empty;
  assign pop_data  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pipe_sink.sv
// Cycle-exact monitor for the pipeline result stream. A start pulse opens a
// window of TIMEOUT cycles; every valid sample equal to the latched target is
// queued with its cycle index for the host to drain.
module pipe_sink
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  pipe_sink_if.slave       bus,
  output logic             busy,
  output logic             found,
  output logic             timeout,
  output logic             overflow
);

  localparam int                 EW   = WIDTH + STAMP_W;
  localparam logic [STAMP_W-1:0] LAST = STAMP_W'(TIMEOUT - 1);

  state_t             state_q;
  state_t             state_d;
  logic [STAMP_W-1:0] count_q;
  logic [WIDTH-1:0]   target_q;
  logic               open_run;
  logic               last;
  logic               match;
  logic               drop;
  logic [EW-1:0]      head;

  // Next-state logic plus the per-cycle strobes that the window logic uses.
  always_comb begin
    state_d  = state_q;
    open_run = 1'b0;
    last     = 1'b0;
    match    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          open_run = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        match = bus.in_valid && (bus.in_data == target_q);
        last  = (count_q == LAST);
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Window bookkeeping: target latch, cycle counter and the sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      target_q <= '0;
      found    <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else if (open_run) begin
      count_q  <= '0;
      target_q <= target;
      found    <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else if (state_q == RUN) begin
      count_q <= count_q + 1'b1;
      if (match) found    <= 1'b1;
      if (drop)  overflow <= 1'b1;
      if (last && !found && !match) timeout <= 1'b1;
    end
  end

  sink_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (open_run),
    .push      (match),
    .push_data ({bus.in_data, count_q}),
    .pop_ready (bus.out_ready),
    .pop_valid (bus.out_valid),
    .pop_data  (head),
    .drop      (drop)
  );

  assign bus.out_data  = head[EW-1:STAMP_W];
  assign bus.out_stamp = head[STAMP_W-1:0];
  assign busy          = (state_q == RUN);

endmodule

// File: tb/tb_pipe_sink.sv
// Directed bench for pipe_sink (WIDTH=8, DEPTH=4, TIMEOUT=16). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_pipe_sink;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] target;
  logic       busy, found, timeout, overflow;

  int errors = 0;
  int checks = 0;

  pipe_sink_if #(.WIDTH(8)) bus ();

  pipe_sink #(
    .WIDTH   (8),
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .target   (target),
    .bus      (bus),
    .busy     (busy),
    .found    (found),
    .timeout  (timeout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle; returns on the falling edge after the start edge.
  task automatic open_window(input logic [7:0] tgt);
    @(negedge clk);
    start  = 1'b1;
    target = tgt;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Pop entries and compare against consecutive stamps carrying one data value.
  task automatic drain_expect(input string tag, input int n, input logic [7:0] first_stamp,
                              input logic [7:0] data_v);
    entry_t got, exp;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s valid[%0d]: out_valid=%b required 1", tag, i, bus.out_valid);
      end
      got = '{data: bus.out_data, stamp: bus.out_stamp};
      exp = '{data: data_v, stamp: 8'(first_stamp + 8'(i))};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL %s entry[%0d]: data=%0d stamp=%0d required data=%0d stamp=%0d",
                 tag, i, got.data, got.stamp, exp.data, exp.stamp);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s empty: out_valid=%b required 0", tag, bus.out_valid);
    end
  endtask

  // target=16, data=count*2: one match at count 8.
  task automatic run_single_match(input string tag);
    open_window(8'd16);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(k * 2);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== (k >= 8) || found !== (k >= 8)) begin
        errors++;
        $display("[TB] FAIL %s latency k=%0d: out_valid=%b found=%b required %b", tag, k,
                 bus.out_valid, found, k >= 8);
      end
      checks++;
      if (busy !== (k < 15)) begin
        errors++;
        $display("[TB] FAIL %s busy k=%0d: busy=%b required %b", tag, k, busy, k < 15);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (timeout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s flags: timeout=%b overflow=%b required 0 0", tag, timeout, overflow);
    end
    drain_expect(tag, 1, 8'd8, 8'd16);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_valid, busy, found, timeout, overflow} !== 5'b0 ||
        bus.out_data !== 8'd0 || bus.out_stamp !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset: valid=%b busy=%b found=%b timeout=%b overflow=%b data=%0d stamp=%0d required all 0",
               bus.out_valid, busy, found, timeout, overflow, bus.out_data, bus.out_stamp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_match;
    run_single_match("single");
  endtask

  task automatic test_no_match;
    logic saw_valid = 1'b0;
    open_window(8'd200);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(k);
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nomatch valid: out_valid seen=%b required 0", saw_valid);
    end
    checks++;
    if (timeout !== 1'b1 || found !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nomatch flags: timeout=%b found=%b busy=%b overflow=%b required 1 0 0 0",
               timeout, found, busy, overflow);
    end
  endtask

  task automatic test_overflow;
    open_window(8'd5);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = (k < 6);
      bus.in_data  = 8'd5;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || found !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow flags: overflow=%b found=%b timeout=%b required 1 1 0",
               overflow, found, timeout);
    end
    drain_expect("overflow", 4, 8'd0, 8'd5);
  endtask

  task automatic test_push_pop_full;
    open_window(8'd9);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid  = (k < 5);
      bus.in_data   = 8'd9;
      bus.out_ready = (k == 4);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || found !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pushpop flags: overflow=%b found=%b required 0 1", overflow, found);
    end
    drain_expect("pushpop", 4, 8'd1, 8'd9);
  endtask

  task automatic test_reset_midrun;
    open_window(8'd3);
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (k == 2 || k == 4) ? 8'd3 : 8'd0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || found !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun pre: valid=%b found=%b busy=%b required 1 1 1",
               bus.out_valid, found, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, busy, found, timeout, overflow} !== 5'b0 ||
        bus.out_data !== 8'd0 || bus.out_stamp !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midrun async: valid=%b busy=%b found=%b timeout=%b overflow=%b data=%0d stamp=%0d required all 0",
               bus.out_valid, busy, found, timeout, overflow, bus.out_data, bus.out_stamp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_single_match("after_reset");
  endtask

  task automatic test_restart;
    open_window(8'd1);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = (k == 3 || k == 6);
      bus.in_data  = (k == 3) ? 8'd1 : 8'd2;
      start        = (k == 5);
      target       = (k == 5) ? 8'd2 : 8'd1;
      @(negedge clk);
      if (k == 14) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL restart busy14: busy=%b required 1", busy);
        end
      end
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    checks++;
    if (busy !== 1'b0 || found !== 1'b1 || bus.out_valid !== 1'b1 ||
        bus.out_stamp !== 8'd3 || bus.out_data !== 8'd1) begin
      errors++;
      $display("[TB] FAIL restart ignored: busy=%b found=%b valid=%b stamp=%0d data=%0d required 0 1 1 3 1",
               busy, found, bus.out_valid, bus.out_stamp, bus.out_data);
    end
    open_window(8'd7);
    checks++;
    if (found !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart flush: found=%b valid=%b busy=%b timeout=%b required 0 0 1 0",
               found, bus.out_valid, busy, timeout);
    end
    repeat (16) @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart timeout: timeout=%b busy=%b required 1 0", timeout, busy);
    end
  endtask

  // Overall time bound in case the run gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    target        = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_match();
    test_no_match();
    test_overflow();
    test_push_pop_full();
    test_reset_midrun();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
